// File: rtl/cordic_prerotate_if.sv
// cordic_prerotate_if
//   Bundles the sample-side and result-side signals of the CORDIC front end.
//   Parameters must match those of the cordic_prerotate instance it is bound to.
//
//   Handshake: a sample is offered when strobe_in=1 and ena=1 at a clk edge.
//   There is no backpressure. A result is valid for exactly the cycle in which
//   strobe_out=1. Between results, xout/yout/zout hold their last value.
//
//   Optional (macro CORDIC_PREROTATE_QUAD_OUT_EN): quad_out carries the
//   quadrant used for the sample currently on xout/yout/zout.
//
//   modport master : the producer of samples and consumer of results.
//   modport slave  : the cordic_prerotate block.
interface cordic_prerotate_if #(
  parameter int XY_INPUT_WIDTH  = 16,
  parameter int XY_OUTPUT_WIDTH = 18,
  parameter int Z_WIDTH         = 16
);
  logic                       ena;
  logic                       strobe_in;
  logic [XY_INPUT_WIDTH-1:0]  xin;
  logic [XY_INPUT_WIDTH-1:0]  yin;
  logic [Z_WIDTH-1:0]         zin;
  logic [XY_OUTPUT_WIDTH-1:0] xout;
  logic [XY_OUTPUT_WIDTH-1:0] yout;
  logic [Z_WIDTH-1:0]         zout;
  logic                       strobe_out;
`ifdef CORDIC_PREROTATE_QUAD_OUT_EN
  logic [1:0]                 quad_out;
`endif

  modport master (
    output ena, strobe_in, xin, yin, zin,
`ifdef CORDIC_PREROTATE_QUAD_OUT_EN
    input  quad_out,
`endif
    input  xout, yout, zout, strobe_out
  );

  modport slave (
    input  ena, strobe_in, xin, yin, zin,
`ifdef CORDIC_PREROTATE_QUAD_OUT_EN
    output quad_out,
`endif
    output xout, yout, zout, strobe_out
  );
endinterface

// File: rtl/cordic_prerotate.sv
// cordic_prerotate
//   Front end of the CORDIC pipeline. It captures an x/y/z sample on a strobe
//   and sign-extends x/y to the output width. It then pre-rotates by +/-90
//   degrees so the residual phase lies in [-pi/2, pi/2), the range the stage
//   chain converges over. The result appears on the registered outputs with
//   strobe_out, one pipeline stage after capture.
//
//   Ports:
//     clk  - system clock
//     rst  - synchronous, active-high reset; dominates ena and strobe_in
//     bus  - cordic_prerotate_if.slave:
//            ena, strobe_in, xin, yin, zin        (inputs)
//            xout, yout, zout, strobe_out         (outputs)
//            quad_out                             (only with the macro below)
//
//   Optional feature: define CORDIC_PREROTATE_QUAD_OUT_EN to add quad_out[1:0].
//   It carries the quadrant used for the sample on xout/yout/zout.
//
//   Phase is full scale +/-pi, so 2^(Z_WIDTH-2) is pi/2.
module cordic_prerotate #(
  parameter int XY_INPUT_WIDTH  = 16,
  parameter int XY_OUTPUT_WIDTH = 18,
  parameter int Z_WIDTH         = 16
) (
  input  logic                clk,
  input  logic                rst,
  cordic_prerotate_if.slave   bus
);

  localparam int EXT = XY_OUTPUT_WIDTH - XY_INPUT_WIDTH;
  localparam logic [Z_WIDTH-1:0] QUARTER = {2'b01, {(Z_WIDTH-2){1'b0}}};

  // Stage A: captured sample
  logic signed [XY_OUTPUT_WIDTH-1:0] xa, ya;
  logic        [Z_WIDTH-1:0]         za;
  logic                              va;

  // Stage B: registered result
  logic signed [XY_OUTPUT_WIDTH-1:0] xb, yb;
  logic        [Z_WIDTH-1:0]         zb;
  logic                              vb;

  logic signed [XY_OUTPUT_WIDTH-1:0] x_rot, y_rot;
  logic        [Z_WIDTH-1:0]         z_rot;
  logic        [1:0]                 quad;

  always_ff @(posedge clk) begin
    if (rst) begin
      xa <= '0;
      ya <= '0;
      za <= '0;
      va <= 1'b0;
    end else begin
      va <= bus.ena & bus.strobe_in;
      if (bus.ena && bus.strobe_in) begin
        xa <= {{EXT{bus.xin[XY_INPUT_WIDTH-1]}}, bus.xin};
        ya <= {{EXT{bus.yin[XY_INPUT_WIDTH-1]}}, bus.yin};
        za <= bus.zin;
      end
    end
  end

  // The top two phase bits pick the quadrant. 01 is [pi/2, pi) and 10 is
  // [-pi, -pi/2). The other two quadrants are already inside the stage-chain
  // range. Negation is done at the wider output width, so negating the most
  // negative input is exact.
  assign quad = za[Z_WIDTH-1:Z_WIDTH-2];

  always_comb begin
    x_rot = xa;
    y_rot = ya;
    z_rot = za;
    case (quad)
      2'b01: begin
        x_rot = -ya;
        y_rot = xa;
        z_rot = za - QUARTER;
      end
      2'b10: begin
        x_rot = ya;
        y_rot = -xa;
        z_rot = za + QUARTER;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xb <= '0;
      yb <= '0;
      zb <= '0;
      vb <= 1'b0;
    end else begin
      vb <= bus.ena & va;
      if (bus.ena && va) begin
        xb <= x_rot;
        yb <= y_rot;
        zb <= z_rot;
      end
    end
  end

  assign bus.xout       = xb;
  assign bus.yout       = yb;
  assign bus.zout       = zb;
  assign bus.strobe_out = vb;

`ifdef CORDIC_PREROTATE_QUAD_OUT_EN
  logic [1:0] quad_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      quad_b <= 2'b00;
    end else if (bus.ena && va) begin
      quad_b <= quad;
    end
  end

  assign bus.quad_out = quad_b;
`endif

endmodule

// File: tb/tb_cordic_prerotate.sv
// tb_cordic_prerotate
//   Directed bench for cordic_prerotate with default parameters (16/18/16).
//   A behavioural model predicts each result from the phase value in plain
//   integer arithmetic. A compare process checks the DUT against the model on
//   every cycle. Directed vectors carry hand-computed literal expectations.
module tb_cordic_prerotate;

  localparam int XI = 16;
  localparam int XO = 18;
  localparam int ZW = 16;
  localparam int EW = 2 + ZW + XO + XO;

  typedef struct packed {
    logic [1:0]    q;
    logic [ZW-1:0] z;
    logic [XO-1:0] y;
    logic [XO-1:0] x;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_prerotate_if #(.XY_INPUT_WIDTH(XI), .XY_OUTPUT_WIDTH(XO), .Z_WIDTH(ZW)) bus ();

  cordic_prerotate #(.XY_INPUT_WIDTH(XI), .XY_OUTPUT_WIDTH(XO), .Z_WIDTH(ZW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A phase of +pi/2 or more needs a -90 rotation. A phase below -pi/2 needs
  // a +90 rotation. Everything else passes through unchanged.
  function automatic logic [EW-1:0] model(input int x, input int y, input int z);
    int xo, yo, zo, q;
    xo = x; yo = y; zo = z;
    if (z >= 16384) begin
      xo = -y; yo = x; zo = z - 16384; q = 1;
    end else if (z < -16384) begin
      xo = y; yo = -x; zo = z + 16384; q = 2;
    end else begin
      q = (z < 0) ? 3 : 0;
    end
    model = {q[1:0], zo[ZW-1:0], yo[XO-1:0], xo[XO-1:0]};
  endfunction

  logic [EW-1:0] exp_q[$];
  int            due_q[$];
  logic [EW-1:0] pend;
  logic          pend_v = 1'b0;
  logic [EW-1:0] hold = '0;
  int            cyc = 0;

  // A sample accepted at one edge is produced at the next edge if ena is
  // still high there. Reset discards everything.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pend_v = 1'b0;
      exp_q.delete();
      due_q.delete();
      hold = '0;
    end else begin
      if (bus.ena && pend_v) begin
        exp_q.push_back(pend);
        due_q.push_back(cyc);
      end
      pend_v = bus.ena && bus.strobe_in;
      if (pend_v) pend = model($signed(bus.xin), $signed(bus.yin), $signed(bus.zin));
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    exp_t e;
    int   due;
    if (bus.strobe_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe_out", 1, 0);
      end else begin
        e   = exp_t'(exp_q.pop_front());
        due = due_q.pop_front();
        check("strobe_latency", cyc, due);
        hold = e;
      end
    end else begin
      check("strobe_out_low", longint'(bus.strobe_out), 0);
      if (due_q.size() != 0 && due_q[0] <= cyc) begin
        check("missing_strobe_out", 0, 1);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
    e = exp_t'(hold);
    check("xout", longint'($signed(bus.xout)), longint'($signed(e.x)));
    check("yout", longint'($signed(bus.yout)), longint'($signed(e.y)));
    check("zout", longint'($signed(bus.zout)), longint'($signed(e.z)));
`ifdef CORDIC_PREROTATE_QUAD_OUT_EN
    check("quad_out", longint'(bus.quad_out), longint'(e.q));
`endif
  end

  // ---------------- driver tasks ----------------
  // Offer one sample, then check the result one edge after the accepting
  // edge against hand-computed literals.
  task automatic send_and_expect(input string name, input int x, input int y, input int z,
                                 input int ex, input int ey, input int ez, input int eq);
    bus.xin = x[XI-1:0];
    bus.yin = y[XI-1:0];
    bus.zin = z[ZW-1:0];
    bus.strobe_in = 1'b1;
    @(negedge clk);
    bus.strobe_in = 1'b0;
    check({name, "_early"}, longint'(bus.strobe_out), 0);
    @(negedge clk);
    check({name, "_strobe"}, longint'(bus.strobe_out), 1);
    check({name, "_x"}, longint'($signed(bus.xout)), longint'(ex));
    check({name, "_y"}, longint'($signed(bus.yout)), longint'(ey));
    check({name, "_z"}, longint'($signed(bus.zout)), longint'(ez));
`ifdef CORDIC_PREROTATE_QUAD_OUT_EN
    check({name, "_q"}, longint'(bus.quad_out), longint'(eq));
`else
    if (eq < 0) check({name, "_q"}, eq, 0);
`endif
    @(negedge clk);
    check({name, "_single"}, longint'(bus.strobe_out), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    exp_t m;
    bus.ena = 1'b1;
    bus.strobe_in = 1'b1;
    bus.xin = '0;
    bus.yin = '0;
    bus.zin = '0;

    // Pin the model with literals.
    m = exp_t'(model(100, 50, 20000));
    check("model_pos90_x", longint'($signed(m.x)), -50);
    check("model_pos90_z", longint'($signed(m.z)), 3616);
    m = exp_t'(model(-32768, -32768, -32768));
    check("model_neg_pi_y", longint'($signed(m.y)), 32768);
    check("model_neg_pi_q", longint'(m.q), 2);

    // Reset with strobe high and data toggling.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.xin = (i % 2) ? 16'h7fff : 16'h8000;
      bus.yin = 16'(i * 1234);
      bus.zin = 16'(20000 + i);
      check("reset_strobe_out", longint'(bus.strobe_out), 0);
      check("reset_xout", longint'(bus.xout), 0);
    end
    bus.strobe_in = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_zout", longint'(bus.zout), 0);

    send_and_expect("pass",   100, 50, 10,     100, 50, 10, 0);
    send_and_expect("pos90",  100, 50, 20000,  -50, 100, 3616, 1);
    send_and_expect("neg90",  100, 50, -20000, 50, -100, -3616, 2);
    send_and_expect("neg_pi", -32768, -32768, -32768, -32768, 32768, -16384, 2);
    send_and_expect("z_p16384", 7, -9, 16384,  9, 7, 0, 1);
    send_and_expect("z_m16384", 7, -9, -16384, 7, -9, -16384, 3);
    send_and_expect("z_p16383", 7, -9, 16383,  7, -9, 16383, 0);

    // Streaming: a strobe every cycle, with ena dropped from cycle 4.
    for (int i = 0; i < 8; i++) begin
      bus.ena = (i < 4);
      bus.strobe_in = 1'b1;
      bus.xin = 16'(1000 + i);
      bus.yin = 16'(-200 * i);
      bus.zin = 16'(9000 * i - 30000);
      @(negedge clk);
    end
    bus.strobe_in = 1'b0;
    bus.ena = 1'b1;
    repeat (4) @(negedge clk);

    // Reset while a sample is in flight drops it.
    bus.xin = 16'd5; bus.yin = 16'd6; bus.zin = 16'd7;
    bus.strobe_in = 1'b1;
    @(negedge clk);
    bus.strobe_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("drain_empty", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cordic_prerotate.md
Name: cordic_prerotate

Overview:
- Front end of the CORDIC pipeline; sits directly upstream of stage 0 of the cordic_new_stage chain.
- Captures x/y/z samples on a strobe and sign-extends x/y with guard bits.
- Pre-rotates by ±90° so the residual angle lies in [-pi/2, pi/2), which is the convergence range of the stage chain.
- Outputs are registered, with a strobe aligned to the data.

Parameters:
- XY_INPUT_WIDTH, 16, width of signed x/y inputs.
- XY_OUTPUT_WIDTH, 18, width of signed x/y outputs; must be >= XY_INPUT_WIDTH+1 (+2 recommended for stage growth).
- Z_WIDTH, 16, width of signed phase in and out; full scale ±pi, so 2^(Z_WIDTH-2) = pi/2 (16384 for 16 bits; 8192 = pi/4 = stage-0 atan constant).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  pipeline enable; low flushes valid bits.
- strobe_in  in  1  input sample valid.
- xin  in  XY_INPUT_WIDTH  signed x.
- yin  in  XY_INPUT_WIDTH  signed y.
- zin  in  Z_WIDTH  signed phase.
- xout  out  XY_OUTPUT_WIDTH  pre-rotated x, to stage 0 xin.
- yout  out  XY_OUTPUT_WIDTH  pre-rotated y, to stage 0 yin.
- zout  out  Z_WIDTH  residual phase, to stage 0 zin.
- strobe_out  out  1  output valid; 2 cycles after the accepted strobe_in.

Behaviour:
- Reset (rst=1 at a clk rising edge):
  - xout, yout, zout = 0; strobe_out = 0; internal stage registers and valid bits = 0.
  - rst dominates ena and strobe_in.
  - Reset mid-operation drops all in-flight samples; the first strobe_out after reset comes from a strobe_in accepted on or after the first edge with rst=0.
- Stage A (capture):
  - On an edge with ena=1 and strobe_in=1: register xin/yin sign-extended to XY_OUTPUT_WIDTH, register zin, set vA=1.
  - ena=1, strobe_in=0: vA=0, data registers hold.
  - ena=0: vA=0, data registers hold.
- Stage B (rotate), when ena=1 and vA=1; quadrant q = zA[Z_WIDTH-1:Z_WIDTH-2]:
  - q=01 (z in [pi/2, pi)): xout=-yA, yout=xA, zout=zA-2^(Z_WIDTH-2).
  - q=10 (z in [-pi, -pi/2)): xout=yA, yout=-xA, zout=zA+2^(Z_WIDTH-2).
  - q=00 or 11: pass through unchanged.
  - strobe_out=1.
- Stage B outputs hold when ena=0 or vA=0. strobe_out=0 on every cycle without a fresh result.
- Arithmetic:
  - Two's complement throughout; z add/subtract wraps modulo 2^Z_WIDTH (cannot overflow given the quadrant condition).
  - Negation is done at XY_OUTPUT_WIDTH, so -(-2^(XY_INPUT_WIDTH-1)) is exact; no saturation is needed.
- Throughput: one sample per cycle; back-to-back strobes are fully pipelined.
- ena falling while a sample is in stage A: the sample is discarded (vA cleared).
- Boundaries:
  - z = +pi/2 exactly (16384): q=01, residual 0.
  - z = -pi/2 (-16384): q=11, passes.
  - z = -pi (-32768): q=10, residual -16384.

Optional Feature:
- Macro: CORDIC_PREROTATE_QUAD_OUT_EN.
- Defined: adds output port quad_out [1:0], registered alongside xout and equal to the q used for that sample (reset 0). Downstream uses it for debug and phase-unwrap.
- Undefined: the port does not exist and no extra flops are generated; all other behaviour is identical.

Test Plan:
- Reset: assert rst for 5 cycles with strobe_in=1 and data toggling -> xout=yout=zout=0 and strobe_out=0 throughout, and for 2 cycles after release.
- Pass-through: x=100, y=50, z=10, one strobe -> exactly 2 cycles later one strobe_out pulse with xout=100, yout=50, zout=10.
- +90 rotation: x=100, y=50, z=20000 -> xout=-50, yout=100, zout=3616.
- -90 rotation and extremes:
  - x=100, y=50, z=-20000 -> xout=50, yout=-100, zout=-3616.
  - x=-32768, y=-32768, z=-32768 -> xout=-32768, yout=+32768 (18-bit), zout=-16384.
- Streaming and ena: strobe every cycle for 8 samples with ena dropped on cycle 4 -> sample accepted at cycle 3 lost, samples at cycles 4-and-later absent while ena=0, strobe_out pulses match accepted samples in order and with 2-cycle latency.
- Boundary: z=16384 -> zout=0 rotated; z=-16384 -> unrotated; z=16383 -> unrotated; with the macro defined, quad_out = 01, 11, 00 respectively.
